obi_uart_tx: RTL and testbench

// - Transmit path of the OBI UART: TX FIFO plus serializer, directly downstream of the register block.
// - Consumes THR write strobes/data and LCR/FCR fields; drives the serial line.
// - Returns THR/TX-empty status and FIFO-reset self-clear to the register block.
// - Bit timing comes from an external 16x-oversample baud tick (baud generator driven by DLL/DLM).

---
 rtl/obi_uart_tx.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_obi_uart_tx.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_uart_tx.sv
// obi_uart_tx: transmit half of the OBI UART.
// A TX FIFO (or single holding register when FIFOs are disabled) feeds a
// start/data/parity/stop serializer paced by a 16x-oversample baud tick.
// Optional build macro: OBI_UART_TX_CTS_FLOW_EN adds a cts_i input that
// gates the start of each new frame.
module obi_uart_tx #(
   parameter int FifoDepth      = 16,
   parameter int OversampleRate = 16
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        baud_tick_i,
`ifdef OBI_UART_TX_CTS_FLOW_EN
   input  logic                        cts_i,
`endif
   input  logic                        thr_write_i,
   input  logic [7:0]                  thr_data_i,
   input  logic [7:0]                  lcr_i,
   input  logic                        fifo_en_i,
   input  logic                        fifo_rst_i,
   output logic                        fifo_rst_clr_o,
   output logic                        thr_empty_o,
   output logic                        tx_empty_o,
   output logic [$clog2(FifoDepth):0]  fifo_level_o,
   output logic                        overflow_o,
   output logic                        txd_o
);

   localparam int PtrW   = $clog2(FifoDepth);
   localparam int LevelW = PtrW + 1;
   localparam int CntW   = $clog2(OversampleRate * 2);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } txState_e;

   // FIFO storage and bookkeeping
   logic [7:0]        fifoMem_q [FifoDepth];
   logic [PtrW-1:0]   wrPtr_q, wrPtr_d;
   logic [PtrW-1:0]   rdPtr_q, rdPtr_d;
   logic [LevelW-1:0] level_q, level_d;
   logic [LevelW-1:0] capacity;
   logic              fifoEn_q;
   logic              fifoEmpty;
   logic              fifoFull;
   logic              fifoClear;
   logic              push;
   logic              pop;
   logic [7:0]        fifoHead;

   // Status and pulse outputs
   logic              overflow_q, overflow_d;
   logic              rstClr_q, rstClr_d;
   logic              thrEmpty_q;
   logic              txEmpty_q;

   // Serializer state
   txState_e          state_q, state_d;
   logic [CntW-1:0]   tickCnt_q, tickCnt_d;
   logic [2:0]        bitIdx_q, bitIdx_d;
   logic [7:0]        shift_q, shift_d;
   logic [3:0]        frameLcr_q, frameLcr_d;
   logic              parity_q, parity_d;
   logic [2:0]        lastBitIdx;
   logic [CntW-1:0]   bitLast;
   logic [CntW-1:0]   stopLast;
   logic              ctsOk;
   logic              txdLine;
   logic              unusedLcr;

   assign unusedLcr = lcr_i[7];

`ifdef OBI_UART_TX_CTS_FLOW_EN
   assign ctsOk = cts_i;
`else
   assign ctsOk = 1'b1;
`endif

   assign fifoEmpty = (level_q == '0);
   assign fifoHead  = fifoMem_q[rdPtr_q];

   // Parity over the active word bits only; stick parity overrides the data.
   function automatic logic framePar(input logic [7:0] data, input logic [5:0] lcr);
      logic [7:0] masked;
      masked = data & (8'hFF >> (2'd3 - lcr[1:0]));
      if (lcr[5]) begin
         return ~lcr[4];
      end else if (lcr[4]) begin
         return ^masked;
      end else begin
         return ~^masked;
      end
   endfunction

   // FIFO next-state: capacity shrinks to one entry in holding-register mode,
   // a pop frees a slot in the same cycle, and any clear request wins.
   always_comb begin
      capacity   = fifo_en_i ? LevelW'(FifoDepth) : LevelW'(1);
      fifoFull   = (level_q >= capacity);
      fifoClear  = fifo_rst_i || (fifo_en_i != fifoEn_q);
      push       = thr_write_i && (!fifoFull || pop) && !fifoClear;
      overflow_d = thr_write_i && fifoFull && !pop && !fifoClear;
      rstClr_d   = fifo_rst_i && !rstClr_q;
      wrPtr_d    = wrPtr_q;
      rdPtr_d    = rdPtr_q;
      level_d    = level_q;
      if (push) begin
         wrPtr_d = wrPtr_q + 1'b1;
      end
      if (pop) begin
         rdPtr_d = rdPtr_q + 1'b1;
      end
      if (push && !pop) begin
         level_d = level_q + 1'b1;
      end else if (pop && !push) begin
         level_d = level_q - 1'b1;
      end
      if (fifoClear) begin
         wrPtr_d = '0;
         rdPtr_d = '0;
         level_d = '0;
      end
   end

   // FIFO pointers, occupancy and the fifo-enable history used to spot toggles.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wrPtr_q  <= '0;
         rdPtr_q  <= '0;
         level_q  <= '0;
         fifoEn_q <= 1'b0;
      end else begin
         wrPtr_q  <= wrPtr_d;
         rdPtr_q  <= rdPtr_d;
         level_q  <= level_d;
         fifoEn_q <= fifo_en_i;
      end
   end

   // Data array needs no reset: only entries between the pointers are ever read.
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifoMem_q[wrPtr_q] <= thr_data_i;
      end
   end

   // Bit-boundary limits taken from the frame's latched line settings.
   always_comb begin
      lastBitIdx = 3'd4 + {1'b0, frameLcr_q[1:0]};
      bitLast    = CntW'(OversampleRate - 1);
      stopLast   = CntW'(OversampleRate - 1);
      if (frameLcr_q[2]) begin
         if (frameLcr_q[1:0] == 2'd0) begin
            stopLast = CntW'((OversampleRate * 3) / 2 - 1);
         end else begin
            stopLast = CntW'(OversampleRate * 2 - 1);
         end
      end
   end

   // Serializer next-state: everything advances only on a baud tick and the
   // tick counter restarts at every bit boundary.
   always_comb begin
      state_d    = state_q;
      tickCnt_d  = tickCnt_q;
      bitIdx_d   = bitIdx_q;
      shift_d    = shift_q;
      frameLcr_d = frameLcr_q;
      parity_d   = parity_q;
      pop        = 1'b0;
      case (state_q)
         StIdle: begin
            if (baud_tick_i && !fifoEmpty && ctsOk) begin
               pop        = 1'b1;
               state_d    = StStart;
               tickCnt_d  = '0;
               bitIdx_d   = '0;
               shift_d    = fifoHead;
               frameLcr_d = lcr_i[3:0];
               parity_d   = framePar(fifoHead, lcr_i[5:0]);
            end
         end
         StStart: begin
            if (baud_tick_i) begin
               if (tickCnt_q == bitLast) begin
                  tickCnt_d = '0;
                  state_d   = StData;
               end else begin
                  tickCnt_d = tickCnt_q + 1'b1;
               end
            end
         end
         StData: begin
            if (baud_tick_i) begin
               if (tickCnt_q == bitLast) begin
                  tickCnt_d = '0;
                  shift_d   = {1'b0, shift_q[7:1]};
                  if (bitIdx_q == lastBitIdx) begin
                     state_d = frameLcr_q[3] ? StParity : StStop;
                  end else begin
                     bitIdx_d = bitIdx_q + 1'b1;
                  end
               end else begin
                  tickCnt_d = tickCnt_q + 1'b1;
               end
            end
         end
         StParity: begin
            if (baud_tick_i) begin
               if (tickCnt_q == bitLast) begin
                  tickCnt_d = '0;
                  state_d   = StStop;
               end else begin
                  tickCnt_d = tickCnt_q + 1'b1;
               end
            end
         end
         StStop: begin
            if (baud_tick_i) begin
               if (tickCnt_q == stopLast) begin
                  tickCnt_d = '0;
                  state_d   = StIdle;
               end else begin
                  tickCnt_d = tickCnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d   = StIdle;
            tickCnt_d = '0;
         end
      endcase
   end

   // Serializer registers; reset drops any frame in flight.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         tickCnt_q  <= '0;
         bitIdx_q   <= '0;
         shift_q    <= '0;
         frameLcr_q <= '0;
         parity_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         tickCnt_q  <= tickCnt_d;
         bitIdx_q   <= bitIdx_d;
         shift_q    <= shift_d;
         frameLcr_q <= frameLcr_d;
         parity_q   <= parity_d;
      end
   end

   // Status flags and one-cycle pulses back to the register block.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         thrEmpty_q <= 1'b1;
         txEmpty_q  <= 1'b1;
         overflow_q <= 1'b0;
         rstClr_q   <= 1'b0;
      end else begin
         thrEmpty_q <= (level_d == '0);
         txEmpty_q  <= (level_d == '0) && (state_d == StIdle);
         overflow_q <= overflow_d;
         rstClr_q   <= rstClr_d;
      end
   end

   // Line level for the current bit; idle and stop are both mark (high).
   always_comb begin
      txdLine = 1'b1;
      case (state_q)
         StStart:  txdLine = 1'b0;
         StData:   txdLine = shift_q[0];
         StParity: txdLine = parity_q;
         default:  txdLine = 1'b1;
      endcase
   end

   // Break follows the live LCR so software sees it immediately.
   assign txd_o          = lcr_i[6] ? 1'b0 : txdLine;
   assign thr_empty_o    = thrEmpty_q;
   assign tx_empty_o     = txEmpty_q;
   assign fifo_level_o   = level_q;
   assign overflow_o     = overflow_q;
   assign fifo_rst_clr_o = rstClr_q;

endmodule

// File: tb/tb_obi_uart_tx.sv
// tb_obi_uart_tx: directed and randomized checks of obi_uart_tx against a
// waveform model built from UART framing rules.
module tb_obi_uart_tx;

   localparam int FifoDepth = 16;
   localparam int Os        = 16;
   localparam int LevelW    = $clog2(FifoDepth) + 1;

   logic              clk_i;
   logic              rst_i;
   logic              baud_tick_i;
   logic              thr_write_i;
   logic [7:0]        thr_data_i;
   logic [7:0]        lcr_i;
   logic              fifo_en_i;
   logic              fifo_rst_i;
   logic              fifo_rst_clr_o;
   logic              thr_empty_o;
   logic              tx_empty_o;
   logic [LevelW-1:0] fifo_level_o;
   logic              overflow_o;
   logic              txd_o;
`ifdef OBI_UART_TX_CTS_FLOW_EN
   logic              cts_i;
`endif

   int nChecks  = 0;
   int nFails   = 0;
   int ovfCount = 0;
   int clrCount = 0;
   bit expWave[$];

   obi_uart_tx #(
      .FifoDepth      (FifoDepth),
      .OversampleRate (Os)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .baud_tick_i    (baud_tick_i),
`ifdef OBI_UART_TX_CTS_FLOW_EN
      .cts_i          (cts_i),
`endif
      .thr_write_i    (thr_write_i),
      .thr_data_i     (thr_data_i),
      .lcr_i          (lcr_i),
      .fifo_en_i      (fifo_en_i),
      .fifo_rst_i     (fifo_rst_i),
      .fifo_rst_clr_o (fifo_rst_clr_o),
      .thr_empty_o    (thr_empty_o),
      .tx_empty_o     (tx_empty_o),
      .fifo_level_o   (fifo_level_o),
      .overflow_o     (overflow_o),
      .txd_o          (txd_o)
   );

   // 100 MHz-style free-running clock
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   // Pulse counters, sampled on the active edge so registered pulses are seen once
   always @(posedge clk_i) begin
      if (overflow_o === 1'b1) ovfCount++;
      if (fifo_rst_clr_o === 1'b1) clrCount++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nChecks++;
      assert (observed === expected) else begin
         nFails++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // One-cycle THR write strobe
   task automatic applyStimulus(input logic [7:0] data);
      @(negedge clk_i);
      thr_write_i = 1'b1;
      thr_data_i  = data;
      @(negedge clk_i);
      thr_write_i = 1'b0;
   endtask

   // Expected line level per baud tick for one frame (tick every cycle)
   task automatic buildWave(input logic [7:0] data, input logic [7:0] lcr);
      int nBits;
      int ones;
      int stopTicks;
      bit pbit;
      expWave.delete();
      nBits = 5 + int'(lcr[1:0]);
      repeat (Os) expWave.push_back(1'b0);
      ones = 0;
      for (int b = 0; b < nBits; b++) begin
         ones += int'(data[b]);
         repeat (Os) expWave.push_back(data[b]);
      end
      if (lcr[3]) begin
         if (lcr[5]) pbit = ~lcr[4];
         else if (lcr[4]) pbit = (ones % 2 == 1);
         else pbit = (ones % 2 == 0);
         repeat (Os) expWave.push_back(pbit);
      end
      if (!lcr[2]) stopTicks = Os;
      else if (nBits == 5) stopTicks = (Os * 3) / 2;
      else stopTicks = Os * 2;
      repeat (stopTicks) expWave.push_back(1'b1);
   endtask

   // Follow one frame sample by sample; act=1 pulses fifo_rst like the register
   // block would, act=2 changes LCR, both at sample actAt.
   task automatic expectFrame(input logic [7:0] data, input logic [7:0] lcr, input bit started,
                              input bit checkIdle, input int actAt, input int act,
                              input logic [7:0] actLcr, input string tag);
      int waited;
      int errs;
      int firstBad;
      logic lastEmpty;
      buildWave(data, lcr);
      if (!started) begin
         waited = 0;
         do begin
            @(negedge clk_i);
            waited++;
         end while (txd_o !== 1'b0 && waited < 2000);
         if (txd_o !== 1'b0) begin
            checkOutput({tag, " start timeout"}, 32'(txd_o), 32'd0);
            return;
         end
      end
      errs      = 0;
      firstBad  = -1;
      lastEmpty = 1'bx;
      for (int i = 0; i < expWave.size(); i++) begin
         if (i > 0) @(negedge clk_i);
         if (txd_o !== expWave[i]) begin
            errs++;
            if (firstBad < 0) firstBad = i;
         end
         if (act == 1 && i == actAt) fifo_rst_i = 1'b1;
         if (act == 1 && i == actAt + 2) fifo_rst_i = 1'b0;
         if (act == 2 && i == actAt) lcr_i = actLcr;
         lastEmpty = tx_empty_o;
      end
      checkOutput($sformatf("%s bad samples (first at %0d)", tag, firstBad), errs, 0);
      if (checkIdle) begin
         checkOutput({tag, " tx_empty on last stop tick"}, 32'(lastEmpty), 32'd0);
         @(negedge clk_i);
         checkOutput({tag, " tx_empty after frame"}, 32'(tx_empty_o), 32'd1);
      end
   endtask

   // Count start-like low samples over a window of idle line
   task automatic countLows(input int cycles, output int lows);
      lows = 0;
      repeat (cycles) begin
         @(negedge clk_i);
         if (txd_o !== 1'b1) lows++;
      end
   endtask

   initial begin
      logic [31:0] r;
      logic [7:0]  d0, d1, d2;
      logic [7:0]  lcrV;
      logic [7:0]  q[4];
      int          ovfBefore;
      int          clrBefore;
      int          lows;

      rst_i       = 1'b1;
      baud_tick_i = 1'b0;
      thr_write_i = 1'b0;
      thr_data_i  = 8'h00;
      lcr_i       = 8'h03;
      fifo_en_i   = 1'b1;
      fifo_rst_i  = 1'b0;
`ifdef OBI_UART_TX_CTS_FLOW_EN
      cts_i       = 1'b1;
`endif
      $display("[TB] obi_uart_tx bench start");

      // Reset values
      repeat (3) @(negedge clk_i);
      checkOutput("reset txd", 32'(txd_o), 32'd1);
      checkOutput("reset thr_empty", 32'(thr_empty_o), 32'd1);
      checkOutput("reset tx_empty", 32'(tx_empty_o), 32'd1);
      checkOutput("reset level", 32'(fifo_level_o), 32'd0);
      checkOutput("reset overflow", 32'(overflow_o), 32'd0);
      checkOutput("reset fifo_rst_clr", 32'(fifo_rst_clr_o), 32'd0);
      rst_i = 1'b0;
      repeat (3) @(negedge clk_i);

      // 8N1 0xA5, tick every cycle
      baud_tick_i = 1'b1;
      lcr_i = 8'h03;
      applyStimulus(8'hA5);
      expectFrame(8'hA5, 8'h03, 1'b0, 1'b1, -1, 0, 8'h00, "8N1 A5");

      // 7E2 0x41
      lcr_i = 8'h1E;
      applyStimulus(8'h41);
      expectFrame(8'h41, 8'h1E, 1'b0, 1'b1, -1, 0, 8'h00, "7E2 41");

      // 5-bit with 1.5 stop bits
      lcr_i = 8'h04;
      d0 = 8'($urandom);
      applyStimulus(d0);
      expectFrame(d0, 8'h04, 1'b0, 1'b1, -1, 0, 8'h00, "5N1.5");

      // Random framing formats
      for (int k = 0; k < 6; k++) begin
         r = $urandom;
         lcrV = {2'b00, r[5:0]};
         d0 = 8'($urandom);
         lcr_i = lcrV;
         applyStimulus(d0);
         expectFrame(d0, lcrV, 1'b0, 1'b1, -1, 0, 8'h00, $sformatf("rand lcr=%02h d=%02h", lcrV, d0));
      end

      // Back-to-back frames from a pre-filled FIFO
      lcr_i = 8'h03;
      baud_tick_i = 1'b0;
      d0 = 8'($urandom);
      d1 = 8'($urandom);
      d2 = 8'($urandom);
      applyStimulus(d0);
      applyStimulus(d1);
      applyStimulus(d2);
      checkOutput("b2b level", 32'(fifo_level_o), 32'd3);
      checkOutput("b2b thr_empty", 32'(thr_empty_o), 32'd0);
      baud_tick_i = 1'b1;
      expectFrame(d0, 8'h03, 1'b0, 1'b0, -1, 0, 8'h00, "b2b frame0");
      expectFrame(d1, 8'h03, 1'b0, 1'b0, -1, 0, 8'h00, "b2b frame1");
      expectFrame(d2, 8'h03, 1'b0, 1'b1, -1, 0, 8'h00, "b2b frame2");

      // Fill to capacity without ticks: one write too many is dropped
      baud_tick_i = 1'b0;
      ovfBefore = ovfCount;
      for (int k = 0; k < FifoDepth + 1; k++) applyStimulus(8'($urandom));
      repeat (2) @(negedge clk_i);
      checkOutput("full level", 32'(fifo_level_o), FifoDepth);
      checkOutput("full overflow pulses", ovfCount - ovfBefore, 1);
      checkOutput("full thr_empty", 32'(thr_empty_o), 32'd0);

      // Toggling fifo_en clears; holding-register mode keeps only one byte
      fifo_en_i = 1'b0;
      repeat (2) @(negedge clk_i);
      checkOutput("toggle clears level", 32'(fifo_level_o), 32'd0);
      checkOutput("toggle thr_empty", 32'(thr_empty_o), 32'd1);
      ovfBefore = ovfCount;
      d0 = 8'($urandom);
      d1 = 8'($urandom);
      applyStimulus(d0);
      applyStimulus(d1);
      repeat (2) @(negedge clk_i);
      checkOutput("thr mode level", 32'(fifo_level_o), 32'd1);
      checkOutput("thr mode overflow pulses", ovfCount - ovfBefore, 1);
      baud_tick_i = 1'b1;
      expectFrame(d0, 8'h03, 1'b0, 1'b1, -1, 0, 8'h00, "thr mode frame");

      // Full holding register: push and pop in the same cycle both happen
      baud_tick_i = 1'b0;
      d0 = 8'($urandom);
      d1 = 8'($urandom);
      applyStimulus(d0);
      ovfBefore = ovfCount;
      thr_write_i = 1'b1;
      thr_data_i  = d1;
      baud_tick_i = 1'b1;
      @(negedge clk_i);
      thr_write_i = 1'b0;
      checkOutput("push+pop full level", 32'(fifo_level_o), 32'd1);
      expectFrame(d0, 8'h03, 1'b1, 1'b0, -1, 0, 8'h00, "push+pop frame0");
      expectFrame(d1, 8'h03, 1'b0, 1'b1, -1, 0, 8'h00, "push+pop frame1");
      repeat (2) @(negedge clk_i);
      checkOutput("push+pop no overflow", ovfCount - ovfBefore, 0);

      // FIFO reset mid-frame: queue dropped, frame in flight completes
      fifo_en_i = 1'b1;
      baud_tick_i = 1'b0;
      repeat (2) @(negedge clk_i);
      for (int k = 0; k < 4; k++) begin
         q[k] = 8'($urandom);
         applyStimulus(q[k]);
      end
      clrBefore = clrCount;
      baud_tick_i = 1'b1;
      expectFrame(q[0], 8'h03, 1'b0, 1'b1, 40, 1, 8'h00, "fifo_rst frame");
      checkOutput("fifo_rst level", 32'(fifo_level_o), 32'd0);
      @(negedge clk_i);
      checkOutput("fifo_rst clr pulses", clrCount - clrBefore, 1);
      countLows(60, lows);
      checkOutput("fifo_rst no further frames", lows, 0);

      // LCR change mid-frame applies only to the next frame (8N1 -> 8O1)
      baud_tick_i = 1'b0;
      lcr_i = 8'h03;
      d0 = 8'($urandom);
      d1 = 8'($urandom);
      applyStimulus(d0);
      applyStimulus(d1);
      baud_tick_i = 1'b1;
      expectFrame(d0, 8'h03, 1'b0, 1'b0, 30, 2, 8'h0B, "lcr change old frame");
      expectFrame(d1, 8'h0B, 1'b0, 1'b1, -1, 0, 8'h00, "lcr change new frame");

      // Break forces the line low combinationally
      @(negedge clk_i);
      lcr_i = 8'h43;
      #1;
      checkOutput("break txd", 32'(txd_o), 32'd0);
      @(negedge clk_i);
      lcr_i = 8'h03;
      #1;
      checkOutput("break release txd", 32'(txd_o), 32'd1);

`ifdef OBI_UART_TX_CTS_FLOW_EN
      // Flow control holds frames until the peer is ready
      cts_i = 1'b0;
      d0 = 8'($urandom);
      applyStimulus(d0);
      countLows(50, lows);
      checkOutput("cts low holds line", lows, 0);
      checkOutput("cts low level", 32'(fifo_level_o), 32'd1);
      cts_i = 1'b1;
      @(negedge clk_i);
      checkOutput("cts start next tick", 32'(txd_o), 32'd0);
      expectFrame(d0, 8'h03, 1'b1, 1'b1, -1, 0, 8'h00, "cts frame");
`endif

      // Reset mid-frame aborts the frame and clears the queue
      d0 = 8'($urandom);
      d1 = 8'($urandom);
      applyStimulus(d0);
      applyStimulus(d1);
      repeat (20) @(negedge clk_i);
      rst_i = 1'b1;
      #1;
      checkOutput("midframe reset txd", 32'(txd_o), 32'd1);
      checkOutput("midframe reset level", 32'(fifo_level_o), 32'd0);
      checkOutput("midframe reset tx_empty", 32'(tx_empty_o), 32'd1);
      checkOutput("midframe reset thr_empty", 32'(thr_empty_o), 32'd1);
      @(negedge clk_i);
      rst_i = 1'b0;
      countLows(40, lows);
      checkOutput("after reset line idle", lows, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
